prom_read_arbiter: RTL and testbench

PROM_READ_ARBITER -- requirements
Module: prom_read_arbiter

---
 rtl/prom_arb_pkg.sv | 14 +
 rtl/rr_arb2.sv | 20 ++
 rtl/prom_read_arbiter.sv | 114 +++++++++++
 tb/tb_prom_read_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/prom_arb_pkg.sv
// rtl/prom_arb_pkg.sv - shared state encoding and default widths for the PROM read arbiter
package prom_arb_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 4;
    localparam int LW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; ptr=0 favours requester 0 on a tie
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = ptr ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/prom_read_arbiter.sv
// rtl/prom_read_arbiter.sv - shares one synchronous ROM between two burst readers
module prom_read_arbiter
    import prom_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [LW-1:0] len0,
    output logic          gnt0,
    output logic          valid0,
    output logic          done0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [LW-1:0] len1,
    output logic          gnt1,
    output logic          valid1,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_dout
);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic          ptr;
    logic          owner;
    logic [LW-1:0] cnt;
    logic [1:0]    gnt_w;
    logic          last;

    assign last = (cnt == '0);

    // Requests are only looked at while idle, which makes bursts non-preemptible.
    rr_arb2 u_rr_arb2 (
        .req (({req1, req0})),
        .ptr (ptr),
        .en  (state == IDLE),
        .gnt (gnt_w)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_w != 2'b00) state_nxt = BURST;
            BURST:   if (last) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= 1'b0;
            owner    <= 1'b0;
            cnt      <= '0;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            valid0   <= 1'b0;
            valid1   <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
        end else begin
            gnt0   <= gnt_w[0];
            gnt1   <= gnt_w[1];
            // ROM data lags the address by one clock, so valid is rom_cs delayed.
            valid0 <= rom_cs & ~owner;
            valid1 <= rom_cs & owner;
            done0  <= (state == BURST) && last && !owner;
            done1  <= (state == BURST) && last && owner;
            case (state)
                IDLE: begin
                    if (gnt_w != 2'b00) begin
                        owner    <= gnt_w[1];
                        ptr      <= ~gnt_w[1];
                        rom_addr <= gnt_w[1] ? addr1 : addr0;
                        cnt      <= gnt_w[1] ? len1 : len0;
                        rom_cs   <= 1'b1;
                    end else begin
                        rom_cs <= 1'b0;
                    end
                end
                BURST: begin
                    if (!last) begin
                        rom_addr <= rom_addr + AW'(1);
                        cnt      <= cnt - LW'(1);
                        rom_cs   <= 1'b1;
                    end else begin
                        rom_cs <= 1'b0;
                    end
                end
                default: rom_cs <= 1'b0;
            endcase
        end
    end

    assign rdata = (valid0 | valid1) ? rom_dout : '0;

endmodule

// File: tb/tb_prom_read_arbiter.sv
// tb/tb_prom_read_arbiter.sv - directed and randomized bursts against a behavioural arbiter model
module tb_prom_read_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] addr0, addr1;
    logic [3:0] len0, len1;
    logic       gnt0, gnt1, valid0, valid1, done0, done1;
    logic [3:0] rdata;
    logic       rom_cs;
    logic [7:0] rom_addr;
    logic [3:0] rom_dout;

    logic [3:0] rom [256];

    int n_assert = 0;
    int n_fail   = 0;

    // model: pending requests, their parameters, and which requester wins a tie
    bit pend [2];
    int maddr [2];
    int mlen [2];
    int fav;

    prom_read_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .addr0    (addr0),
        .len0     (len0),
        .gnt0     (gnt0),
        .valid0   (valid0),
        .done0    (done0),
        .req1     (req1),
        .addr1    (addr1),
        .len1     (len1),
        .gnt1     (gnt1),
        .valid1   (valid1),
        .done1    (done1),
        .rdata    (rdata),
        .rom_cs   (rom_cs),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_dout <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int n, input bit on, input int a, input int l);
        if (n == 0) begin
            req0 = on; addr0 = a[7:0]; len0 = l[3:0];
        end else begin
            req1 = on; addr1 = a[7:0]; len1 = l[3:0];
        end
        pend[n]  = on;
        maddr[n] = a;
        mlen[n]  = l;
    endtask

    function automatic int exp_winner();
        if (pend[0] && pend[1]) return fav;
        return pend[0] ? 0 : 1;
    endfunction

    // Called at the negedge of the grant cycle G; returns at the negedge of the dead cycle G+l+2.
    task automatic check_burst(input int n, input int a, input int l);
        bit cs_e, v_e, d_e;
        for (int c = 0; c <= l + 2; c++) begin
            cs_e = (c <= l);
            v_e  = (c >= 1) && (c <= l + 1);
            d_e  = (c == l + 1);
            chk("rom_cs", rom_cs, cs_e);
            if (cs_e) chk("rom_addr", rom_addr, (a + c) & 255);
            chk("valid_own", (n == 1) ? valid1 : valid0, v_e);
            chk("valid_other", (n == 1) ? valid0 : valid1, 0);
            chk("done_own", (n == 1) ? done1 : done0, d_e);
            chk("done_other", (n == 1) ? done0 : done1, 0);
            chk("gnt_own", (n == 1) ? gnt1 : gnt0, c == 0);
            chk("gnt_other", (n == 1) ? gnt0 : gnt1, 0);
            chk("rdata", rdata, v_e ? rom[(a + c - 1) & 255] : 4'h0);
            if (c <= l + 1) @(negedge clk);
        end
    endtask

    // mode 0: owner drops req; 1: random follow-up; 2: owner drops, other raises mid-burst; 3: all held
    task automatic grant_and_burst(input int n, input int max_wait, input int mode);
        int waited, ga, gl;
        waited = 0;
        while (!(gnt0 || gnt1) && waited < max_wait) begin
            @(negedge clk);
            waited++;
        end
        chk("gnt_seen", gnt0 | gnt1, 1);
        chk("gnt_who", {gnt1, gnt0}, (n == 0) ? 1 : 2);
        if (gnt0 | gnt1) begin
            ga  = maddr[n];
            gl  = mlen[n];
            fav = 1 - n;
            case (mode)
                0: set_req(n, 0, 0, 0);
                1: begin
                    if ($urandom_range(1) == 1) set_req(n, 1, $urandom_range(255), $urandom_range(15));
                    else set_req(n, 0, $urandom_range(255), $urandom_range(15));
                    if (!pend[1 - n] && $urandom_range(1) == 1)
                        set_req(1 - n, 1, $urandom_range(255), $urandom_range(15));
                end
                2: begin
                    set_req(n, 0, 0, 0);
                    set_req(1 - n, 1, $urandom_range(255), $urandom_range(15));
                end
                default: ;
            endcase
            check_burst(n, ga, gl);
        end
    endtask

    initial begin
        int r;
        for (int i = 0; i < 256; i++) rom[i] = 4'($urandom);
        reset = 1'b1;
        fav   = 0;
        set_req(0, 0, 0, 0);
        set_req(1, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_rom_cs", rom_cs, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_valid", {valid1, valid0}, 0);
        chk("rst_done", {done1, done0}, 0);
        chk("rst_rdata", rdata, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_rom_cs", rom_cs, 0);
        chk("idle_gnt", {gnt1, gnt0}, 0);

        // single burst from 0x10, four nibbles
        set_req(0, 1, 8'h10, 3);
        @(negedge clk);
        grant_and_burst(0, 4, 0);

        // wrap across 0xFF
        set_req(1, 1, 8'hFE, 2);
        @(negedge clk);
        grant_and_burst(1, 4, 0);

        // minimum burst
        set_req(0, 1, 8'h55, 0);
        @(negedge clk);
        grant_and_burst(0, 4, 0);

        // late request from requester 1 waits for the dead cycle
        set_req(0, 1, 8'h20, 5);
        @(negedge clk);
        grant_and_burst(0, 4, 2);
        @(negedge clk);
        grant_and_burst(1, 0, 0);

        // reset at the third nibble of an eight-nibble burst
        set_req(0, 1, 8'h80, 7);
        @(negedge clk);
        r = 0;
        while (!gnt0 && r < 4) begin
            @(negedge clk);
            r++;
        end
        chk("rst_burst_gnt0", gnt0, 1);
        repeat (3) @(negedge clk);
        chk("rst_burst_valid0", valid0, 1);
        chk("rst_burst_rdata", rdata, rom[8'h82]);
        set_req(1, 1, 8'h40, 2);
        reset = 1'b1;
        #1;
        chk("mid_rst_rom_cs", rom_cs, 0);
        chk("mid_rst_rom_addr", rom_addr, 0);
        chk("mid_rst_gnt", {gnt1, gnt0}, 0);
        chk("mid_rst_valid", {valid1, valid0}, 0);
        chk("mid_rst_done", {done1, done0}, 0);
        chk("mid_rst_rdata", rdata, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_no_done", {done1, done0}, 0);
        end
        reset = 1'b0;
        fav   = 0;

        // both requests held: grants alternate starting with requester 0
        @(negedge clk);
        grant_and_burst(0, 0, 3);
        @(negedge clk);
        grant_and_burst(1, 0, 3);
        @(negedge clk);
        grant_and_burst(0, 0, 3);
        @(negedge clk);
        grant_and_burst(1, 0, 3);
        set_req(0, 0, 0, 0);
        set_req(1, 0, 0, 0);
        @(negedge clk);
        chk("drop_all_gnt", {gnt1, gnt0}, 0);

        // randomized traffic
        for (int it = 0; it < 24; it++) begin
            if (!pend[0] && !pend[1]) begin
                r = $urandom_range(1, 3);
                if (r[0]) set_req(0, 1, $urandom_range(255), $urandom_range(15));
                if (r[1]) set_req(1, 1, $urandom_range(255), $urandom_range(15));
            end
            @(negedge clk);
            grant_and_burst(exp_winner(), 0, 1);
        end
        set_req(0, 0, 0, 0);
        set_req(1, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("final_idle", {rom_cs, gnt1, gnt0}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
